fifo_burst_reader: RTL

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

---
 rtl/fifo_burst_reader.sv | 112 +++++++++++
 1 files changed

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - pops a commanded burst from a show-ahead FIFO onto a valid/ready stream
module fifo_burst_reader #(
    parameter int DWIDTH = 32,
    parameter int LWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [LWIDTH-1:0] cmd_len,
    output logic              cmd_ready,
    input  logic [DWIDTH-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_ren,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One extra bit so a full 2^LWIDTH-word burst is representable
    localparam logic [LWIDTH:0] REM_ONE = {{LWIDTH{1'b0}}, 1'b1};

    state_t          state;
    state_t          state_nx;
    logic [LWIDTH:0] remaining;
    logic            cmd_fire;
    logic            beat_fire;
    logic            pop;

    // State register; reset abandons any burst in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake decode; a pop only happens when the output register is free or draining
    always_comb begin
        state_nx  = state;
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        cmd_fire  = cmd_valid & (state == IDLE);
        beat_fire = m_valid & m_ready;
        pop       = (state == BURST) & ~fifo_empty & (remaining != '0) & (~m_valid | m_ready);
        fifo_ren  = pop;
        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    state_nx = BURST;
                end
            end
            BURST: begin
                if (pop && (remaining == REM_ONE)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (beat_fire) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Words still to be popped in the current burst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
        end else if (cmd_fire) begin
            remaining <= {1'b0, cmd_len} + REM_ONE;
        end else if (pop) begin
            remaining <= remaining - REM_ONE;
        end
    end

    // Output register: loads on pop, empties on a transfer that is not refilled the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (pop) begin
            m_data  <= fifo_dout;
            m_valid <= 1'b1;
            m_last  <= (remaining == REM_ONE);
        end else if (beat_fire) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

    // Completion pulse in the first IDLE cycle after the final beat leaves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= (state == DRAIN) & beat_fire;
        end
    end

endmodule
